// File: rtl/button_debouncer.sv
// Purpose: synchronizes a bouncy push-button pad and debounces it into a clean level,
//          with one-cycle press/release strobes and a long-press level.
// Ports  : clk, rst (async active-high) | btn_raw (async pad) |
//          btn_clean, press_pulse, release_pulse, long_press (all registered).
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from a btn_raw change to btn_clean.
// Backpressure: none; free-running conditioning stage with no handshake.
module button_debouncer #(
    parameter int SYNC_STAGES       = 2,
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_clean,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST      = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX      = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE_MAX  = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   btn_sync;
    state_t                 state;
    logic [DW-1:0]          deb_cnt;
    logic [HW-1:0]          hold_cnt;

    // Plain shift chain; only the last stage is ever looked at by the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign btn_sync = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            deb_cnt       <= '0;
            hold_cnt      <= '0;
            btn_clean     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;

            // Hold time keeps running through a pending release, so a release
            // bounce that returns to PRESSED does not restart the long-press timer.
            // The accepted-release branch below overrides these assignments.
            if (state == PRESSED || state == RELEASE_WAIT) begin
                if (hold_cnt != HOLD_MAX) begin
                    hold_cnt <= hold_cnt + 1'b1;
                end
                if (hold_cnt == HOLD_PRE_MAX) begin
                    long_press <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (btn_sync) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= DW'(1);
                    end
                end

                PRESS_WAIT: begin
                    if (!btn_sync) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state       <= PRESSED;
                        deb_cnt     <= '0;
                        btn_clean   <= 1'b1;
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    if (!btn_sync) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= DW'(1);
                    end
                end

                RELEASE_WAIT: begin
                    if (btn_sync) begin
                        state   <= PRESSED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state         <= IDLE;
                        deb_cnt       <= '0;
                        btn_clean     <= 1'b0;
                        release_pulse <= 1'b1;
                        long_press    <= 1'b0;
                        hold_cnt      <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONG_PRESS_CYCLES=10: any accepted level change lands on the 6th edge after btn_raw moves.
// Outputs are sampled 1 ns after each rising edge; inputs change at that same point.
module tb_button_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_clean;
    logic press_pulse;
    logic release_pulse;
    logic long_press;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_debouncer #(
        .SYNC_STAGES      (2),
        .DEBOUNCE_CYCLES  (4),
        .LONG_PRESS_CYCLES(10)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_clean    (btn_clean),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic c, input logic pp,
                           input logic rp, input logic lp);
        chk({tag, " btn_clean"}, btn_clean, c);
        chk({tag, " press_pulse"}, press_pulse, pp);
        chk({tag, " release_pulse"}, release_pulse, rp);
        chk({tag, " long_press"}, long_press, lp);
    endtask

    // Six edges after btn_raw moved to 'to': the level flips on edge 6 together
    // with exactly one strobe. For a release, long_press is expected high from
    // edge lp_on up to edge 5 and low again on edge 6.
    task automatic run_edge(input string tag, input logic to, input int lp_on);
        for (int i = 1; i <= 6; i++) begin
            step();
            chk_all($sformatf("%s e%0d", tag, i),
                    (i == 6) ? to : !to,
                    (i == 6) && to,
                    (i == 6) && !to,
                    !to && (i >= lp_on) && (i < 6));
        end
    endtask

    // n edges with btn_clean steady at c, no strobes, long_press high from step lp_from.
    task automatic steady(input string tag, input int n, input logic c, input int lp_from);
        for (int i = 1; i <= n; i++) begin
            step();
            chk_all($sformatf("%s s%0d", tag, i), c, 1'b0, 1'b0, i >= lp_from);
        end
    endtask

    logic bounce_pat [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        // 1: reset with the button already held, then full latency to the press.
        rst     = 1'b1;
        btn_raw = 1'b1;
        repeat (3) step();
        chk_all("t1 in reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        run_edge("t1 press", 1'b1, 99);
        steady("t1 hold", 1, 1'b1, 99);
        btn_raw = 1'b0;
        run_edge("t1 release", 1'b0, 99);

        // 2: clean press; released early enough that the hold timer stays below 10.
        btn_raw = 1'b1;
        run_edge("t2 press", 1'b1, 99);
        steady("t2 hold", 2, 1'b1, 99);
        btn_raw = 1'b0;
        run_edge("t2 release", 1'b0, 99);

        // 3: press bounce, each run of ones is one sample short of qualifying.
        for (int i = 0; i < 8; i++) begin
            btn_raw = bounce_pat[i];
            step();
            chk_all($sformatf("t3 bounce s%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        btn_raw = 1'b0;
        steady("t3 settle", 6, 1'b0, 99);

        // 4: release bounce of 3 low samples is rejected; then a real release.
        // Press lands on edge 6; the hold timer reaches 10 on edge 16, which is
        // the 4th edge of the final release window.
        btn_raw = 1'b1;
        run_edge("t4 press", 1'b1, 99);
        btn_raw = 1'b0;
        steady("t4 low", 3, 1'b1, 99);
        btn_raw = 1'b1;
        steady("t4 back", 3, 1'b1, 99);
        btn_raw = 1'b0;
        run_edge("t4 release", 1'b0, 4);

        // 5: 30-cycle press, long_press rises 10 edges after btn_clean and holds.
        btn_raw = 1'b1;
        run_edge("t5 press", 1'b1, 99);
        steady("t5 hold", 24, 1'b1, 10);
        btn_raw = 1'b0;
        run_edge("t5 release", 1'b0, 1);

        // 6: reset during a long press clears outputs asynchronously, no release strobe.
        btn_raw = 1'b1;
        run_edge("t6 press", 1'b1, 99);
        steady("t6 hold", 10, 1'b1, 10);
        rst = 1'b1;
        #2;
        chk_all("t6 async reset", 1'b0, 1'b0, 1'b0, 1'b0);
        steady("t6 in reset", 2, 1'b0, 99);
        rst = 1'b0;
        run_edge("t6 re-press", 1'b1, 99);
        btn_raw = 1'b0;
        run_edge("t6 release", 1'b0, 99);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
